// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_HDR0 = 3'd0,
    ST_HDR1 = 3'd1,
    ST_DATA = 3'd2,
    ST_LAST = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } loader_state_t;

  localparam int unsigned HDR_BYTES  = 2;
  localparam int unsigned WORD_BYTES = 4;

  // Only the header and data phases pull bytes from the source.
  function automatic logic state_accepts(input loader_state_t s);
    logic r;
    case (s)
      ST_HDR0, ST_HDR1, ST_DATA: r = 1'b1;
      default:                   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Byte-stream program loader: 16-bit LE word count header, then LE 32-bit words
// written sequentially to instruction memory while the core is held in reset.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  input  logic              restart,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              core_rst,
  output logic              done,
  output logic              err
);

  localparam int unsigned DEPTH     = 2 ** ADDR_W;
  localparam logic [1:0]  LAST_BYTE = 2'(WORD_BYTES - 1);

  loader_state_t     state_q, state_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [ADDR_W:0]   word_idx_q, word_idx_d;
  logic [15:0]       count_q, count_d;
  logic [31:0]       shift_q, shift_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              xfer_s;
  logic [15:0]       hdr_n_s;
  logic [31:0]       word_s;
  logic              last_word_s;

  assign s_ready  = state_accepts(state_q);
  assign done     = (state_q == ST_DONE);
  assign err      = (state_q == ST_ERR);
  assign core_rst = (state_q != ST_DONE);
  assign we       = we_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;

  assign xfer_s      = s_valid && s_ready;
  assign hdr_n_s     = {s_data, count_q[7:0]};
  // New bytes enter at the top, so after four shifts byte 0 sits in [7:0].
  assign word_s      = {s_data, shift_q[31:8]};
  assign last_word_s = ((32'(word_idx_q) + 32'd1) == 32'(count_q));

  // Next-state and write-port decode.
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    word_idx_d = word_idx_q;
    count_d    = count_q;
    shift_d    = shift_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    case (state_q)
      ST_HDR0: begin
        if (xfer_s) begin
          count_d[7:0] = s_data;
          state_d      = ST_HDR1;
        end else begin
          state_d = ST_HDR0;
        end
      end
      ST_HDR1: begin
        if (xfer_s) begin
          count_d    = hdr_n_s;
          byte_idx_d = 2'd0;
          word_idx_d = '0;
          if (hdr_n_s == 16'd0) begin
            state_d = ST_DONE;
          end else if (32'(hdr_n_s) > DEPTH) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_HDR1;
        end
      end
      ST_DATA: begin
        if (xfer_s) begin
          shift_d    = word_s;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == LAST_BYTE) begin
            we_d       = 1'b1;
            waddr_d    = word_idx_q[ADDR_W-1:0];
            wdata_d    = word_s;
            word_idx_d = word_idx_q + {{ADDR_W{1'b0}}, 1'b1};
            if (last_word_s) begin
              state_d = ST_LAST;
            end else begin
              state_d = ST_DATA;
            end
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_LAST: begin
        state_d = ST_DONE;
      end
      ST_DONE, ST_ERR: begin
        if (restart) begin
          state_d    = ST_HDR0;
          byte_idx_d = 2'd0;
          word_idx_d = '0;
          count_d    = 16'd0;
          shift_d    = 32'd0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_HDR0;
      end
    endcase
  end

  // State, counters and registered write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_HDR0;
      byte_idx_q <= 2'd0;
      word_idx_q <= '0;
      count_q    <= 16'd0;
      shift_q    <= 32'd0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      word_idx_q <= word_idx_d;
      count_q    <= count_d;
      shift_q    <= shift_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: expected writes are derived from
// the byte stream by a reference model and checked by an independent monitor.
module tb_imem_loader;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef logic [7:0] bytes_t[$];
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;
  logic              restart;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;
  logic              core_rst;
  logic              done;
  logic              err;

  wr_t exp_q[$];
  int  checks   = 0;
  int  errors   = 0;
  int  we_count = 0;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .restart(restart), .we(we), .waddr(waddr), .wdata(wdata),
    .core_rst(core_rst), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every write pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && we) begin
      we_count++;
      check("we_core_rst", {31'd0, core_rst}, 32'd1);
      check("we_done", {31'd0, done}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL we_unexpected actual addr=%h data=%h required no write", waddr, wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("waddr", {{(32-ADDR_W){1'b0}}, waddr}, {{(32-ADDR_W){1'b0}}, e.addr});
        check("wdata", wdata, e.data);
      end
    end
  end

  // Reference model: words completed within the first 'delivered' bytes.
  function automatic void model(input bytes_t b, input int delivered);
    int n;
    if (delivered < 2) return;
    n = int'(b[0]) | (int'(b[1]) << 8);
    if (n > DEPTH) return;
    for (int i = 0; i < n; i++) begin
      if (2 + 4 * i + 3 < delivered) begin
        exp_q.push_back(wr_t'{addr: ADDR_W'(i),
                              data: {b[5 + 4 * i], b[4 + 4 * i], b[3 + 4 * i], b[2 + 4 * i]}});
      end
    end
  endfunction

  function automatic bytes_t make_stream(input int n, input logic [31:0] words[$]);
    bytes_t b;
    logic [31:0] w;
    b.push_back(8'(n));
    b.push_back(8'(n >> 8));
    for (int i = 0; i < n; i++) begin
      w = words[i];
      for (int k = 0; k < 4; k++) b.push_back(w[8 * k +: 8]);
    end
    return b;
  endfunction

  // Called on a negedge; returns on the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b, output bit ok);
    int guard;
    bit acc;
    guard   = 0;
    acc     = 1'b0;
    s_valid = 1'b1;
    s_data  = b;
    while (!acc && guard < 50) begin
      acc = s_ready;
      @(posedge clk);
      @(negedge clk);
      guard++;
    end
    s_valid = 1'b0;
    ok      = acc;
  endtask

  task automatic run_load(input bytes_t b, input int max_gap, input int deliver);
    bit ok;
    model(b, deliver);
    for (int i = 0; i < deliver; i++) begin
      if (max_gap > 0) repeat ($urandom_range(1, max_gap)) @(negedge clk);
      send_byte(b[i], ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL byte_accept actual=timeout required=accepted idx=%0d", i);
        return;
      end
    end
  endtask

  // After the final byte of a non-empty load: LAST now, DONE one cycle later.
  task automatic finish_check(input string tag);
    check({tag, "_last_ready"}, {31'd0, s_ready}, 32'd0);
    check({tag, "_last_done"}, {31'd0, done}, 32'd0);
    @(negedge clk);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_core_rst"}, {31'd0, core_rst}, 32'd0);
    check({tag, "_ready"}, {31'd0, s_ready}, 32'd0);
    check({tag, "_drained"}, exp_q.size(), 32'd0);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("rs_core_rst", {31'd0, core_rst}, 32'd1);
    check("rs_done", {31'd0, done}, 32'd0);
    check("rs_err", {31'd0, err}, 32'd0);
    check("rs_ready", {31'd0, s_ready}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, s_ready}, 32'd1);
    check({tag, "_we"}, {31'd0, we}, 32'd0);
    check({tag, "_waddr"}, {{(32-ADDR_W){1'b0}}, waddr}, 32'd0);
    check({tag, "_wdata"}, wdata, 32'd0);
    check({tag, "_core_rst"}, {31'd0, core_rst}, 32'd1);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  initial begin
    bytes_t b;
    logic [31:0] words[$];
    int base;
    int n;

    rst = 1'b1; s_valid = 1'b0; s_data = 8'd0; restart = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst_in");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_out");

    b = '{8'h02, 8'h00, 8'h33, 8'h01, 8'h22, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00};
    run_load(b, 0, b.size());
    finish_check("plan1");

    pulse_restart();
    b = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
    base = we_count;
    run_load(b, 0, b.size());
    finish_check("reload");
    check("reload_we_count", we_count - base, 32'd1);

    pulse_restart();
    base = we_count;
    b = '{8'h00, 8'h00};
    run_load(b, 0, 2);
    check("zero_done", {31'd0, done}, 32'd1);
    check("zero_core_rst", {31'd0, core_rst}, 32'd0);
    repeat (3) @(negedge clk);
    check("zero_no_we", we_count - base, 32'd0);

    pulse_restart();
    b = '{8'h01, 8'h04};
    run_load(b, 0, 2);
    check("ovf_err", {31'd0, err}, 32'd1);
    check("ovf_core_rst", {31'd0, core_rst}, 32'd1);
    s_valid = 1'b1;
    s_data  = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("ovf_ready", {31'd0, s_ready}, 32'd0);
      check("ovf_hold_err", {31'd0, err}, 32'd1);
    end
    s_valid = 1'b0;
    pulse_restart();

    words = {};
    for (int i = 0; i < 3; i++) words.push_back($urandom);
    b = make_stream(3, words);
    base = we_count;
    run_load(b, 0, b.size());
    finish_check("n3_nogap");
    check("n3_nogap_we", we_count - base, 32'd3);
    pulse_restart();
    base = we_count;
    run_load(b, 5, b.size());
    finish_check("n3_gap");
    check("n3_gap_we", we_count - base, 32'd3);

    pulse_restart();
    words = {};
    for (int i = 0; i < 2; i++) words.push_back($urandom);
    b = make_stream(2, words);
    run_load(b, 0, 8);
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_drained", exp_q.size(), 32'd0);
    b = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_load(b, 0, b.size());
    finish_check("deadbeef");

    for (int t = 0; t < 4; t++) begin
      pulse_restart();
      n = $urandom_range(1, 6);
      words = {};
      for (int i = 0; i < n; i++) words.push_back($urandom);
      b = make_stream(n, words);
      base = we_count;
      run_load(b, $urandom_range(0, 2), b.size());
      finish_check("rand");
      check("rand_we", we_count - base, n);
    end

    pulse_restart();
    words = {};
    for (int i = 0; i < DEPTH; i++) words.push_back($urandom);
    b = make_stream(DEPTH, words);
    base = we_count;
    run_load(b, 0, b.size());
    finish_check("full");
    check("full_we", we_count - base, DEPTH);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
